// File: rtl/qmac.sv
`default_nettype none
// ============================================================================
//  Module   : qmac
//  Purpose  : Pipelined signed fixed-point multiply-accumulate unit.
//             Accumulates full-precision products of (a, b) operand pairs
//             over a vector delimited by first/last markers and emits one
//             rounded, saturated N-bit result per vector.
//  Ports    : clk          - clock, rising edge
//             rst          - asynchronous reset, active low
//             in_valid/in_ready            - operand beat handshake
//             in_a, in_b   - signed Q-format operands
//             in_first     - beat restarts the accumulator
//             in_last      - beat closes the vector
//             out_valid/out_ready          - result handshake
//             out_result   - rounded, saturated Q-format result
//             out_overflow - vector saturated or accumulator wrapped
//  Revision : 1.0 - initial release
// ============================================================================
module qmac #(
  parameter int N     = 16,
  parameter int Q     = 12,
  parameter int G     = 8,
  parameter int ROUND = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_a,
  input  logic signed [N-1:0] in_b,
  input  logic                in_first,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_result,
  output logic                out_overflow
);

  localparam int c_PW = 2 * N;       // product width
  localparam int c_AW = 2 * N + G;   // accumulator width
  localparam int c_RW = c_AW + 1;    // rounding width, one extra bit so the bias never wraps

  localparam logic signed [c_RW-1:0] c_RND =
      (ROUND != 0) ? (c_RW'(1) <<< (Q - 1)) : '0;
  localparam logic signed [c_RW-1:0] c_MAX = {{(c_RW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [c_RW-1:0] c_MIN = {{(c_RW-N+1){1'b1}}, {(N-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Flow control: one global advance enable shared by every stage.
  // --------------------------------------------------------------------------
  logic w_stall;
  logic w_adv;

  assign w_stall  = out_valid && !out_ready;
  assign w_adv    = !w_stall;
  assign in_ready = !w_stall;

  // --------------------------------------------------------------------------
  // Stage P: full-precision signed product
  // --------------------------------------------------------------------------
  logic signed [c_PW-1:0] w_prod;
  logic signed [c_PW-1:0] r_prod;
  logic                   r_p_valid;
  logic                   r_p_first;
  logic                   r_p_last;

  // Operands are sign-extended to the product width so the most negative
  // squared value (2^(2N-2)) is represented exactly.
  assign w_prod = $signed({{N{in_a[N-1]}}, in_a}) * $signed({{N{in_b[N-1]}}, in_b});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p_valid <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      r_prod    <= '0;
    end else if (w_adv) begin
      r_p_valid <= in_valid;
      if (in_valid) begin
        r_prod    <= w_prod;
        r_p_first <= in_first;
        r_p_last  <= in_last;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage A: guarded accumulation with sticky wrap detection
  // --------------------------------------------------------------------------
  logic signed [c_AW-1:0] r_acc;
  logic                   r_ovf;
  logic signed [c_AW-1:0] r_fin_acc;
  logic                   r_fin_ovf;
  logic                   r_fin_valid;

  logic signed [c_AW-1:0] w_prod_x;
  logic signed [c_AW-1:0] w_base;
  logic signed [c_AW-1:0] w_sum;
  logic                   w_add_ovf;
  logic                   w_ovf_next;

  assign w_prod_x = {{G{r_prod[c_PW-1]}}, r_prod};
  // A first beat starts from zero, so it can never wrap and clears the flag.
  assign w_base   = r_p_first ? '0 : r_acc;
  assign w_sum    = w_base + w_prod_x;
  assign w_add_ovf = (w_base[c_AW-1] == w_prod_x[c_AW-1]) &&
                     (w_sum[c_AW-1]  != w_base[c_AW-1]);
  assign w_ovf_next = (r_p_first ? 1'b0 : r_ovf) | w_add_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_fin_valid <= 1'b0;
      r_fin_acc   <= '0;
      r_fin_ovf   <= 1'b0;
    end else if (w_adv) begin
      if (r_p_valid) begin
        r_acc <= w_sum;
        r_ovf <= w_ovf_next;
      end
      r_fin_valid <= r_p_valid && r_p_last;
      if (r_p_valid && r_p_last) begin
        r_fin_acc <= w_sum;
        r_fin_ovf <= w_ovf_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage F: round, arithmetic shift, saturate
  // --------------------------------------------------------------------------
  logic signed [c_RW-1:0] w_rnd;
  logic signed [c_RW-1:0] w_shr;
  logic                   w_sat_hi;
  logic                   w_sat_lo;
  logic signed [N-1:0]    w_res;

  assign w_rnd    = $signed({r_fin_acc[c_AW-1], r_fin_acc}) + c_RND;
  assign w_shr    = w_rnd >>> Q;
  assign w_sat_hi = (w_shr > c_MAX);
  assign w_sat_lo = (w_shr < c_MIN);
  assign w_res    = w_sat_hi ? c_MAX[N-1:0] :
                    w_sat_lo ? c_MIN[N-1:0] : w_shr[N-1:0];

  // Advancing while out_valid is high implies the current result is taken,
  // so out_valid simply follows r_fin_valid on every advancing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r_fin_valid;
      if (r_fin_valid) begin
        out_result   <= w_res;
        out_overflow <= r_fin_ovf | w_sat_hi | w_sat_lo;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qmac.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qmac
//  Purpose  : Self-checking bench for qmac. Two instances (ROUND=1 and
//             ROUND=0) share all inputs; results are compared against a
//             behavioural accumulate/round/saturate model and constants.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_qmac;

  localparam int N = 16;
  localparam int Q = 12;
  localparam int G = 8;
  localparam longint AMAX = (longint'(1) <<< 39) - 1;
  localparam longint AMIN = -(longint'(1) <<< 39);
  localparam longint AMOD = longint'(1) <<< 40;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b1;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic         rdy1, rdy0, ov1, ov0, of1, of0;
  logic [N-1:0] res1, res0;

  always #5 clk = ~clk;

  qmac #(.N(N), .Q(Q), .G(G), .ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .out_result(res1), .out_overflow(of1));

  qmac #(.N(N), .Q(Q), .G(G), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .out_result(res0), .out_overflow(of0));

  int checks = 0;
  int errors = 0;
  bit rand_rdy = 1'b0;

  // Reference model state and result queues ({overflow, result}).
  longint       m_acc = 0;
  bit           m_ovf = 1'b0;
  logic [N:0]   exp1[$];
  logic [N:0]   exp0[$];
  logic [N:0]   got1[$];
  logic [N:0]   got0[$];
  longint       got_t[$];

  function automatic logic [N:0] finalise(input longint acc, input bit ovf, input bit rnd);
    longint r;
    bit     sat;
    sat = 1'b0;
    r = (acc + (rnd ? longint'(2048) : longint'(0))) >>> Q;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    return {ovf | sat, r[N-1:0]};
  endfunction

  task automatic model_beat(input logic [N-1:0] a, input logic [N-1:0] b, input bit f, input bit l);
    longint p, s;
    p = longint'($signed(a)) * longint'($signed(b));
    if (f) begin m_acc = 0; m_ovf = 1'b0; end
    s = m_acc + p;
    if (s > AMAX) begin s = s - AMOD; m_ovf = 1'b1; end
    else if (s < AMIN) begin s = s + AMOD; m_ovf = 1'b1; end
    m_acc = s;
    if (l) begin
      exp1.push_back(finalise(m_acc, m_ovf, 1'b1));
      exp0.push_back(finalise(m_acc, m_ovf, 1'b0));
    end
  endtask

  task automatic clear_q();
    exp1.delete(); exp0.delete(); got1.delete(); got0.delete(); got_t.delete();
  endtask

  // Results are recorded half a cycle before the edge that takes them.
  always @(negedge clk) begin
    if (rst && out_ready && ov1) begin
      got1.push_back({of1, res1});
      got_t.push_back(longint'($time));
    end
    if (rst && out_ready && ov0) got0.push_back({of0, res0});
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Presents one beat until it is accepted, then updates the model.
  task automatic send_beat(input logic [N-1:0] a, input logic [N-1:0] b, input bit f, input bit l);
    int tries;
    tries = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l;
    forever begin
      @(negedge clk);
      if (rdy1) begin
        @(posedge clk);
        model_beat(a, b, f, l);
        #1;
        break;
      end
      tries++;
      if (tries > 1000) begin
        checks++; errors++;
        $display("FAIL send_beat_timeout got=in_ready_low exp=accept");
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, output bit ok);
    int cyc;
    cyc = 0;
    while ((got1.size() < n || got0.size() < n) && cyc < 2000) begin
      @(posedge clk); cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    ok = (got1.size() == n) && (got0.size() == n);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    checks++; if (ov1 !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov1); end
    checks++; if (res1 !== '0)   begin errors++; $display("FAIL reset_out_result got=%h exp=0000", res1); end
    checks++; if (of1 !== 1'b0)  begin errors++; $display("FAIL reset_out_overflow got=%b exp=0", of1); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", rdy1); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_held got=%b exp=1", rdy1); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    send_beat(16'h1800, 16'h2000, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL latency_k got=%b exp=0", ov1); end
    @(negedge clk);
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL latency_k1 got=%b exp=0", ov1); end
    @(negedge clk);
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL latency_k2 got=%b exp=1", ov1); end
    checks++; if ({of1, res1} !== 17'h0_3000) begin errors++; $display("FAIL single_r1 got=%h exp=03000", {of1, res1}); end
    checks++; if ({of0, res0} !== 17'h0_3000) begin errors++; $display("FAIL single_r0 got=%h exp=03000", {of0, res0}); end
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    clear_q();
  endtask

  task automatic test_sat();
    bit ok;
    send_beat(16'hE800, 16'h2000, 1'b1, 1'b1);
    send_beat(16'h8000, 16'h8000, 1'b1, 1'b1);
    wait_got(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_count got=%0d exp=2", got1.size()); end
    checks++; if (got1[0] !== 17'h0_D000) begin errors++; $display("FAIL neg_product got=%h exp=0d000", got1[0]); end
    checks++; if (got1[1] !== 17'h1_7FFF) begin errors++; $display("FAIL sat_pos got=%h exp=17fff", got1[1]); end
    checks++; if (got0[1] !== 17'h1_7FFF) begin errors++; $display("FAIL sat_pos_r0 got=%h exp=17fff", got0[1]); end
    clear_q();
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 4; i++) send_beat(16'h1000, 16'h1000, i == 0, i == 3);
    for (int i = 0; i < 3; i++) send_beat(16'h7000, 16'h7000, i == 0, i == 2);
    send_beat(16'h1000, 16'h0800, 1'b1, 1'b1);
    send_beat(16'hF000, 16'h1000, 1'b1, 1'b1);
    send_beat(16'h0000, 16'h1234, 1'b1, 1'b1);
    wait_got(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_count got=%0d exp=5", got1.size()); end
    checks++; if (got1[0] !== 17'h0_4000) begin errors++; $display("FAIL b2b_vec4 got=%h exp=04000", got1[0]); end
    checks++; if (got1[1] !== 17'h1_7FFF) begin errors++; $display("FAIL b2b_vec3_sat got=%h exp=17fff", got1[1]); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got1[i] !== exp1[i] || got0[i] !== exp0[i]) begin
        errors++;
        $display("FAIL b2b_model[%0d] got=%h/%h exp=%h/%h", i, got1[i], got0[i], exp1[i], exp0[i]);
      end
    end
    checks++; if (got_t[1] - got_t[0] != 30) begin errors++; $display("FAIL b2b_window got=%0d exp=30", got_t[1] - got_t[0]); end
    checks++; if (got_t[4] - got_t[2] != 20) begin errors++; $display("FAIL b2b_per_cycle got=%0d exp=20", got_t[4] - got_t[2]); end
    clear_q();
  endtask

  task automatic test_round();
    bit ok;
    send_beat(16'h0001, 16'h0800, 1'b1, 1'b1);
    send_beat(16'hFFFF, 16'h0800, 1'b1, 1'b1);
    wait_got(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL round_count got=%0d exp=2", got1.size()); end
    checks++; if (got1[0] !== 17'h0_0001) begin errors++; $display("FAIL round_pos_r1 got=%h exp=00001", got1[0]); end
    checks++; if (got0[0] !== 17'h0_0000) begin errors++; $display("FAIL round_pos_r0 got=%h exp=00000", got0[0]); end
    checks++; if (got1[1] !== 17'h0_0000) begin errors++; $display("FAIL round_neg_r1 got=%h exp=00000", got1[1]); end
    checks++; if (got0[1] !== 17'h0_FFFF) begin errors++; $display("FAIL round_neg_r0 got=%h exp=0ffff", got0[1]); end
    clear_q();
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    out_ready = 1'b0;
    send_beat(16'h1800, 16'h2000, 1'b1, 1'b1);
    cyc = 0;
    while (ov1 !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", ov1); end
    checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", rdy1); end
    in_valid = 1'b1; in_a = 16'h1000; in_b = 16'h1000; in_first = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ov1 !== 1'b1 || res1 !== 16'h3000 || of1 !== 1'b0 || rdy1 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got=%b/%h/%b/%b exp=1/3000/0/0", i, ov1, res1, of1, rdy1);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_beat(16'h1000, 16'h1000, 1'b1, 1'b0);
    send_beat(16'h2000, 16'h0800, 1'b0, 1'b1);
    wait_got(2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_count got=%0d exp=2", got1.size()); end
    checks++; if (got1[0] !== 17'h0_3000) begin errors++; $display("FAIL bp_first got=%h exp=03000", got1[0]); end
    checks++; if (got1[1] !== 17'h0_2000) begin errors++; $display("FAIL bp_after got=%h exp=02000", got1[1]); end
    clear_q();
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    send_beat(16'h8000, 16'h8000, 1'b1, 1'b1);
    send_beat(16'h1000, 16'h1000, 1'b1, 1'b0);
    send_beat(16'h1000, 16'h1000, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if ({ov1, of1} !== 2'b11) begin errors++; $display("FAIL rm_pre got=%b exp=11", {ov1, of1}); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ov1 !== 1'b0 || res1 !== '0 || of1 !== 1'b0 || rdy1 !== 1'b1) begin
      errors++;
      $display("FAIL rm_clear got=%b/%h/%b/%b exp=0/0000/0/1", ov1, res1, of1, rdy1);
    end
    m_acc = 0; m_ovf = 1'b0;
    clear_q();
    @(negedge clk); rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send_beat(16'h1000, 16'h1000, 1'b0, 1'b1);
    wait_got(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_count got=%0d exp=1", got1.size()); end
    checks++; if (got1[0] !== 17'h0_1000) begin errors++; $display("FAIL rm_fresh got=%h exp=01000", got1[0]); end
    clear_q();
  endtask

  task automatic test_acc_wrap();
    bit ok;
    for (int i = 0; i < 513; i++) send_beat(16'h8000, 16'h8000, i == 0, i == 512);
    wait_got(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_count got=%0d exp=1", got1.size()); end
    checks++; if (got1[0] !== 17'h1_8000) begin errors++; $display("FAIL acc_wrap got=%h exp=18000", got1[0]); end
    checks++; if (got0[0] !== exp0[0]) begin errors++; $display("FAIL acc_wrap_r0 got=%h exp=%h", got0[0], exp0[0]); end
    clear_q();
  endtask

  task automatic test_random();
    bit ok;
    int n, len;
    logic [N-1:0] a, b;
    rand_rdy = 1'b1;
    for (int v = 0; v < 60; v++) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, 8191)) - 16'h1000;
        if ($urandom_range(0, 1) == 1) b = 16'($urandom_range(0, 8191)) - 16'h1000;
        send_beat(a, b, (i == 0) && ($urandom_range(0, 7) != 0), i == len - 1);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    n = exp1.size();
    wait_got(n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got1.size(), n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got1[i] !== exp1[i] || got0[i] !== exp0[i]) begin
        errors++;
        $display("FAIL rand[%0d] got=%h/%h exp=%h/%h", i, got1[i], got0[i], exp1[i], exp0[i]);
      end
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_single();
    test_sat();
    test_back_to_back();
    test_round();
    test_backpressure();
    test_reset_mid();
    test_acc_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qmac.md
# qmac

Pipelined signed fixed-point multiply-accumulate unit. It is the parametrised successor to the `qmult` fixed-point multiplier in the CNN inference datapath. It accepts a stream of (a, b) operand pairs in two's-complement Q-format, delimited by first/last markers, and accumulates their full-precision products in a guarded accumulator. One rounded, saturated N-bit result with an overflow flag is emitted per vector. It sits between the operand fetch stage and the activation/requantisation stage of the convolution engine, with valid/ready handshakes on both sides.

## Interface
- `N`, 16: operand and result width, two's complement.
- `Q`, 12: number of fractional bits in operands and result.
- `G`, 8: accumulator guard bits. The accumulator is 2N+G bits wide.
- `ROUND`, 1: 1 = round half up at bit Q; 0 = truncate (floor).

- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operand beat valid.
- `in_ready`  out  1: beat accepted on an edge where `in_valid && in_ready`.
- `in_a`  in  N: signed operand, Q fractional bits.
- `in_b`  in  N: signed operand, Q fractional bits.
- `in_first`  in  1: beat starts a new vector; the accumulator restarts from this product.
- `in_last`  in  1: beat ends the vector; a result is produced.
- `out_valid`  out  1: result valid. Held until the result is taken.
- `out_ready`  in  1: result consumed on an edge where `out_valid && out_ready`.
- `out_result`  out  N: rounded, saturated result, Q fractional bits.
- `out_overflow`  out  1: the vector saturated or the accumulator wrapped. Qualified by `out_valid`.

## Operation
- Operands are native two's complement; there is no sign-magnitude conversion. The product is the full 2N-bit signed result. (-2^(N-1))² = 2^(2N-2) is exact.
- **Stage P (edge of acceptance):**
  - Register the product, `first`, `last` and `p_valid`.
- **Stage A (next advancing edge with `p_valid`):**
  - `acc_next = first ? sext(prod) : acc + sext(prod)`, computed in 2N+G bits.
  - If the addition overflows (operand signs equal and result sign differs), `acc_next` wraps and the sticky `ovf` is set.
  - `first` clears `ovf` before this check.
  - If `last`, copy `acc_next` and the updated `ovf` into the finalise register `fin_acc`/`fin_ovf`, and set `fin_valid`.
- **Stage F (next advancing edge with `fin_valid`):**
  - Compute `r = (fin_acc + (ROUND ? 2^(Q-1) : 0)) >>> Q`, arithmetic shift.
  - Saturate `r` to [-2^(N-1), 2^(N-1)-1].
  - Load `out_result`, set `out_valid`, and set `out_overflow = fin_ovf | saturated`.
  - The rounding addition uses 2N+G+1 bits internally, so it never wraps.
- A beat with both `first` and `last` yields a single-product result.
- A beat with `first` = 0 and no prior `first` accumulates onto the current `acc`, which is 0 after reset.
- Back-to-back vectors are allowed. The first beat of vector k+1 may enter Stage A on the same edge that vector k moves from `fin` to out.

## Timing
- `stall = out_valid && !out_ready`.
- `in_ready = !stall`, a combinational function of the output registers and `out_ready`.
- When `stall` is asserted, every stage register, `acc` and `ovf` hold.
- When `stall` is deasserted, all stages advance together. `out_valid` clears on the take edge unless a new `fin` loads on the same edge.
- Latency: the last beat is accepted at edge k, and `out_valid` rises after edge k+2 (3-cycle latency). This assumes no stall.
- Throughput: 1 beat per cycle. For vectors of length ≥1, a result can be produced every cycle.
- `out_result` and `out_overflow` are stable while `out_valid && !out_ready`.
- Reset (`rst` low, at any time, including mid-vector or while stalled) clears:
  - `p_valid`, `fin_valid`, `out_valid`
  - `acc`, `ovf`, `out_result`, `out_overflow`
  
  `in_ready` reads 1 during and after reset. A partial vector is discarded, and the first post-reset result reflects only post-reset beats.

## Test plan
In the values below, N=16 and Q=12, so 1.0 = 0x1000.

- Single beat, first=last=1, a=0x1800, b=0x2000, ROUND=1 → `out_result`=0x3000, `out_overflow`=0, `out_valid` 3 cycles after acceptance.
- Single beat a=0xE800 (-1.5), b=0x2000 → 0xD000. Then a=b=0x8000 → +64.0 saturates → 0x7FFF, `out_overflow`=1.
- 4-beat vector, each a=b=0x1000 → 0x4000, overflow 0. Next vector issued immediately, 3 beats of a=0x7000 (7.0), b=0x7000 → 147 saturates → 0x7FFF, overflow 1, results on consecutive valid windows.
- Rounding: a=0x0001, b=0x0800 → 0x0001 with ROUND=1 and 0x0000 with ROUND=0. a=0xFFFF, b=0x0800 → 0x0000 with ROUND=1 and 0xFFFF with ROUND=0.
- Backpressure: `out_ready`=0 while a result is valid and beats keep arriving → `in_ready` drops the same cycle, the result holds stable for 5 cycles, no beat is lost. After `out_ready`=1, the following vector result is correct.
- Reset asserted mid-vector after 2 of 4 beats → all outputs 0 immediately. A fresh 1-beat vector 0x1000×0x1000 then yields 0x1000 with overflow 0.
